// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, stage FSM encoding and ShiftRows column indexing
package aes_pkg;
  localparam int BYTE = 8;
  localparam int DWORD = 32;
  localparam int LENGTH = 128;
  localparam int NCOL = 4;
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  // source column for row r of output column c; 2-bit add wraps mod 4
  function automatic logic [1:0] shift_idx(input logic [1:0] r, input logic [1:0] c);
    return c + r;
  endfunction
endpackage

// File: rtl/sbox_lut.sv
// sbox_lut: combinational forward AES S-box as a 256-entry lookup table
module sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE-1:0] a,
  output logic [BYTE-1:0] y
);
  // full table lookup, every code covered
  always_comb begin
    y = '0;
    case (a)
      8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
      8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
      8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
      8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
      8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
      8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
      8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
      8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
      8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
      8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
      8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
      8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
      8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
      8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
      8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
      8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
      8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
      8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
      8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
      8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
      8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
      8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
      8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
      8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
      8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
      8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
      8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
      8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
      8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
      8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
      8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
      8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
      8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
      8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
      8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
      8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
      8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
      8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
      8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
      8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
      8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
      8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
      8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
      8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
      8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
      8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
      8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
      8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
      8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
      8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
      8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
      8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
      8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
      8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
      8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
      8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
      8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
      8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
      8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
      8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
      8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
      8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
      8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
      8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
    endcase
  end
endmodule

// File: rtl/sub_bytes_shift_rows_seq.sv
// sub_bytes_shift_rows_seq: sequential AES SubBytes+ShiftRows stage; SBOX_PARALLEL_EN selects a 1-cycle 16-S-box build
module sub_bytes_shift_rows_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LENGTH-1:0] inpt,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LENGTH-1:0] oupt,
  output logic              out_valid,
  input  logic              out_ready
);
  state_t state, state_n;
  logic [LENGTH-1:0] buff, nxt, shr;
  logic last;
`ifdef SBOX_PARALLEL_EN
  logic [LENGTH-1:0] sub;
  for (genvar i = 0; i < 4 * NCOL; i++) begin : g_sb
    sbox_lut u_sb (.a(buff[BYTE*i +: BYTE]), .y(sub[BYTE*i +: BYTE]));
  end
  assign nxt = sub;
  assign last = 1'b1;
`else
  logic [1:0] cnt;
  logic [DWORD-1:0] col, scol;
  assign col = buff[DWORD*cnt +: DWORD];
  for (genvar i = 0; i < NCOL; i++) begin : g_sb
    sbox_lut u_sb (.a(col[BYTE*i +: BYTE]), .y(scol[BYTE*i +: BYTE]));
  end
  assign last = cnt == 2'd3;
  // buffer with the current column replaced by its substitution
  always_comb begin
    nxt = buff;
    nxt[DWORD*cnt +: DWORD] = scol;
  end
  // column counter restarts on acceptance and steps through SUB
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= state == IDLE ? 2'd0 : state == SUB ? cnt + 2'd1 : cnt;
`endif
  // ShiftRows of the fully substituted state, registered on the last SUB cycle
  always_comb begin
    shr = '0;
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NCOL; r++)
        shr[DWORD*c + BYTE*r +: BYTE] = nxt[DWORD*shift_idx(2'(r), 2'(c)) + BYTE*r +: BYTE];
  end
  // next state and handshake flags decoded from registered state
  always_comb begin
    state_n = state == IDLE ? (in_valid ? SUB : IDLE) :
              state == SUB  ? (last ? DONE : SUB) :
              (out_ready ? IDLE : DONE);
    in_ready = rst_n && state == IDLE;
    out_valid = state == DONE;
  end
  // state, working buffer and output register
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      buff <= '0;
      oupt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) buff <= inpt;
      else if (state == SUB) buff <= nxt;
      if (state == SUB && last) oupt <= shr;
    end
endmodule

// File: tb/tb_sub_bytes_shift_rows_seq.sv
// tb_sub_bytes_shift_rows_seq: scoreboard bench with directed vectors for the SubBytes+ShiftRows stage
module tb_sub_bytes_shift_rows_seq;
`ifdef SBOX_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam logic [127:0] Z   = '0;
  localparam logic [127:0] E63 = {16{8'h63}};
  localparam logic [127:0] T2  = 128'h00000000_00000000_00000100_00000000;
  localparam logic [127:0] E2  = 128'h63636363_63636363_63636363_63637c63;
  localparam logic [127:0] R   = {4{32'h03020100}};
  localparam logic [127:0] ER  = {4{32'h7b777c63}};
  localparam logic [127:0] P   = 128'h33323130_23222120_13121110_03020100;
  localparam logic [127:0] EP  = 128'h26c97c04_7d77c7b7_7b23fdca_c3938263;
  localparam logic [127:0] X11 = {16{8'h11}};
  localparam logic [127:0] E82 = {16{8'h82}};
  localparam logic [127:0] XFF = {16{8'hff}};
  localparam logic [127:0] E16 = {16{8'h16}};

  logic clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] inpt, oupt;
  int total = 0, bad = 0;
  typedef struct {logic [127:0] d; time t;} exp_t;
  exp_t q[$];

  sub_bytes_shift_rows_seq dut (.clk(clk), .rst_n(rst_n), .inpt(inpt), .in_valid(in_valid),
    .in_ready(in_ready), .oupt(oupt), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] g, input logic [127:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, g, w);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output time ta);
    int n = 0;
    in_valid = 1;
    inpt = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n == 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    ta = $time;
    if (push) q.push_back('{d: e, t: ta});
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n == 200) chk("drain_timeout", 128'(q.size()), 0);
  endtask

  logic pv = 0, pr = 0;
  logic [127:0] po;
  exp_t h;
  always @(negedge clk) begin
    if (rst_n && out_valid && !pv) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", 128'($time - q[0].t), 128'(LAT * 10 + 5));
    end
    if (rst_n && pv && !pr) begin
      chk("hold_valid", 128'(out_valid), 1);
      chk("hold_data", oupt, po);
    end
    if (rst_n && out_valid) chk("in_ready_in_done", 128'(in_ready), 0);
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("pop_empty", 1, 0);
      else begin
        h = q.pop_front();
        chk("data", oupt, h.d);
      end
    end
    pv = rst_n && out_valid;
    pr = out_ready;
    po = oupt;
  end

  initial begin
    time t0, t1, t2;
    rst_n = 0; in_valid = 0; inpt = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_in_ready", 128'(in_ready), 0);
    chk("rst_oupt", oupt, 0);
    rst_n = 1;
    #1;
    chk("rel_in_ready", 128'(in_ready), 1);
    send(Z, E63, 1, t0);
    send(T2, E2, 1, t0);
    send(R, ER, 1, t0);
    in_valid = 0;
    drain();
    out_ready = 0;
    send(P, EP, 1, t0);
    inpt = X11;
    repeat (LAT + 10) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 128'(in_ready), 0);
    end
    chk("bp_out_valid", 128'(out_valid), 1);
    out_ready = 1;
    send(X11, E82, 1, t0);
    in_valid = 0;
    drain();
    send(XFF, E16, 0, t0);
`ifndef SBOX_PARALLEL_EN
    repeat (2) begin
      @(posedge clk); #1;
    end
`endif
    rst_n = 0;
    in_valid = 0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 128'(out_valid), 0);
    chk("mid_rst_oupt", oupt, 0);
    chk("mid_rst_in_ready", 128'(in_ready), 0);
    rst_n = 1;
    #1;
    chk("mid_rel_in_ready", 128'(in_ready), 1);
    send(XFF, E16, 1, t0);
    in_valid = 0;
    drain();
    send(X11, E82, 1, t0);
    send(XFF, E16, 1, t1);
    send(P, EP, 1, t2);
    in_valid = 0;
    chk("ii_1", 128'(t1 - t0), 128'((LAT + 2) * 10));
    chk("ii_2", 128'(t2 - t1), 128'((LAT + 2) * 10));
    drain();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
